// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the CPU's multi-cycle memory interface.
// Captures a strobe edge, waits WAIT_STATES cycles, performs the access, then pulses done.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_e;

  // With no wait states the counter is never consulted, so load zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                read_prev_q, write_prev_q;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
  logic                cap_write_q, cap_write_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                overrun_q, overrun_d;
  logic                read_rise, write_rise, mem_we;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_write_d = cap_write_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    overrun_d   = overrun_q;
    mem_we      = 1'b0;

    read_rise  = read  & ~read_prev_q;
    write_rise = write & ~write_prev_q;

    case (state_q)
      S_IDLE: begin
        if (read_rise && write_rise) begin
          err_d = 1'b1;
        end else if (read_rise || write_rise) begin
          cap_addr_d  = addr;
          cap_wdata_d = wdata;
          cap_write_d = write_rise;
          cnt_d       = WAIT_LOAD;
          state_d     = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (cap_write_q) mem_we  = 1'b1;
        else             rdata_d = mem[cap_addr_q];
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Edges that arrive while an access is in flight are dropped but remembered.
    if (state_q != S_IDLE && (read_rise || write_rise)) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      read_prev_q  <= 1'b0;
      write_prev_q <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      cap_write_q  <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_prev_q  <= read;
      write_prev_q <= write;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
      cap_write_q  <= cap_write_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: the RAM array has no reset; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_addr_q] <= cap_wdata_q;
  end

  assign rdata   = rdata_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one WAIT_STATES=2 instance and one WAIT_STATES=0 instance
// share the stimulus; each step checks the instance it targets.
module tb_mem_responder;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, read, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rdata2, rdata0;
  logic          done2, busy2, err2, ovr2;
  logic          done0, busy0, err0, ovr0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .done(done2), .busy(busy2), .err(err2), .overrun(ovr2)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .done(done0), .busy(busy0), .err(err0), .overrun(ovr0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Full access on the WAIT_STATES=2 instance: done must appear on the 4th cycle after the edge.
  // addr/wdata switch to the *_late values one cycle after the edge to prove operand capture.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [AW-1:0] a_late,
                            input logic [DW-1:0] d, input logic [DW-1:0] d_late,
                            input logic [DW-1:0] exp_rdata);
    read = rd; write = wr; addr = a; wdata = d;
    tick();
    check1({tag, " busy c1"}, busy2, 1'b1);
    check1({tag, " done c1"}, done2, 1'b0);
    addr = a_late; wdata = d_late;
    for (int k = 2; k <= 3; k++) begin
      tick();
      check1({tag, " busy mid"}, busy2, 1'b1);
      check1({tag, " done mid"}, done2, 1'b0);
    end
    tick();
    check1({tag, " done c4"}, done2, 1'b1);
    check1({tag, " busy c4"}, busy2, 1'b1);
    check32({tag, " rdata"}, rdata2, exp_rdata);
    read = 1'b0; write = 1'b0;
    tick();
    check1({tag, " done c5"}, done2, 1'b0);
    check1({tag, " busy c5"}, busy2, 1'b0);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (3) tick();
    check32("rst rdata", rdata2, 32'h0);
    check1("rst done", done2, 1'b0);
    check1("rst busy", busy2, 1'b0);
    check1("rst err", err2, 1'b0);
    check1("rst overrun", ovr2, 1'b0);
    check1("rst busy0", busy0, 1'b0);
    reset = 1'b0;
    tick();

    // Write then read back; writes leave rdata untouched.
    run_access("wr 05C", 1'b0, 1'b1, 9'h05C, 9'h05C, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    run_access("rd 05C", 1'b1, 1'b0, 9'h05C, 9'h05C, 32'h0, 32'h0, 32'hDEADBEEF);

    // Operand capture on both read and write paths.
    run_access("wr 010", 1'b0, 1'b1, 9'h010, 9'h011, 32'h00000011, 32'h0000FFFF, 32'hDEADBEEF);
    run_access("wr 011", 1'b0, 1'b1, 9'h011, 9'h011, 32'h00000022, 32'h00000022, 32'hDEADBEEF);
    run_access("rd 010 cap", 1'b1, 1'b0, 9'h010, 9'h011, 32'h0, 32'h0, 32'h00000011);
    run_access("rd 011", 1'b1, 1'b0, 9'h011, 9'h011, 32'h0, 32'h0, 32'h00000022);

    // Illegal simultaneous request.
    run_access("wr 030", 1'b0, 1'b1, 9'h030, 9'h030, 32'h30303030, 32'h30303030, 32'h00000022);
    read = 1'b1; write = 1'b1; addr = 9'h030; wdata = 32'h00000BAD;
    tick();
    check1("illegal err", err2, 1'b1);
    check1("illegal busy", busy2, 1'b0);
    check1("illegal err0", err0, 1'b1);
    tick();
    check1("illegal err 1cyc", err2, 1'b0);
    check1("illegal busy later", busy2, 1'b0);
    read = 1'b0; write = 1'b0;
    tick();
    run_access("rd 030 after illegal", 1'b1, 1'b0, 9'h030, 9'h030, 32'h0, 32'h0, 32'h30303030);

    // Overrun: write edge during WAIT of a read is dropped and flagged.
    read = 1'b1; addr = 9'h05C;
    tick();
    check1("ovr busy", busy2, 1'b1);
    check1("ovr pre", ovr2, 1'b0);
    read = 1'b0; write = 1'b1; wdata = 32'h0BAD0BAD;
    tick();
    check1("ovr set", ovr2, 1'b1);
    tick();
    tick();
    check1("ovr done", done2, 1'b1);
    check32("ovr rdata", rdata2, 32'hDEADBEEF);
    write = 1'b0;
    tick();
    check1("ovr idle", busy2, 1'b0);
    repeat (3) tick();
    check1("ovr sticky", ovr2, 1'b1);
    run_access("rd 05C no write", 1'b1, 1'b0, 9'h05C, 9'h05C, 32'h0, 32'h0, 32'hDEADBEEF);
    check1("ovr still", ovr2, 1'b1);

    // Reset in the middle of a write.
    run_access("wr 020", 1'b0, 1'b1, 9'h020, 9'h020, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF);
    write = 1'b1; addr = 9'h020; wdata = 32'h12345678;
    tick();
    tick();
    check1("midrst busy", busy2, 1'b1);
    reset = 1'b1;
    #1;
    check32("midrst rdata", rdata2, 32'h0);
    check1("midrst done", done2, 1'b0);
    check1("midrst busy", busy2, 1'b0);
    check1("midrst err", err2, 1'b0);
    check1("midrst overrun", ovr2, 1'b0);
    tick();
    write = 1'b0; reset = 1'b0;
    tick();
    run_access("rd 020 kept", 1'b1, 1'b0, 9'h020, 9'h020, 32'h0, 32'h0, 32'hCAFEF00D);

    // Edge arriving in the DONE cycle counts as busy.
    read = 1'b1; addr = 9'h020;
    repeat (4) tick();
    check1("done-edge done", done2, 1'b1);
    check1("done-edge ovr pre", ovr2, 1'b0);
    read = 1'b0; write = 1'b1; wdata = 32'h0;
    tick();
    check1("done-edge ovr", ovr2, 1'b1);
    check1("done-edge busy", busy2, 1'b0);
    tick();
    tick();
    check1("done-edge no access", busy2, 1'b0);
    write = 1'b0;
    tick();

    // Zero-wait-state instance.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check1("ws0 rst ovr", ovr0, 1'b0);
    check32("ws0 rst rdata", rdata0, 32'h0);
    write = 1'b1; addr = 9'h001; wdata = 32'hA5A5A5A5;
    tick();
    check1("ws0 wr busy", busy0, 1'b1);
    check1("ws0 wr done c1", done0, 1'b0);
    tick();
    check1("ws0 wr done c2", done0, 1'b1);
    write = 1'b0;
    tick();
    check1("ws0 wr idle", busy0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      read = 1'b1;
      tick();
      check1("ws0 rd busy", busy0, 1'b1);
      check1("ws0 rd done c1", done0, 1'b0);
      tick();
      check1("ws0 rd done c2", done0, 1'b1);
      check32("ws0 rd rdata", rdata0, 32'hA5A5A5A5);
      tick();
      check1("ws0 rd idle", busy0, 1'b0);
      read = 1'b0;
      repeat (3) tick();
    end
    check1("ws0 no overrun", ovr0, 1'b0);

    // Level already high when reset releases is seen as an edge; RAM survives reset.
    reset = 1'b1; read = 1'b1; addr = 9'h001;
    tick();
    check32("lvl rst rdata", rdata0, 32'h0);
    reset = 1'b0;
    tick();
    check1("lvl edge busy", busy0, 1'b1);
    tick();
    check1("lvl edge done", done0, 1'b1);
    check32("lvl edge rdata", rdata0, 32'hA5A5A5A5);
    read = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's multi-cycle memory interface; the control unit initiates accesses with read/write strobes, MAR supplies the address, MDR supplies the write data.
- Holds a word-addressed RAM, inserts a configurable number of wait states, and signals completion with a one-cycle done pulse. The control unit's memory states stall until that pulse arrives.
- Read data is held stable for the MDR to load.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 9, word-address width; the RAM depth is 2**ADDR_W.
- WAIT_STATES, 2, number of idle cycles between request capture and the array access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- read  input  1  read request level from the control unit.
- write  input  1  write request level from the control unit.
- addr  input  ADDR_W  word address from MAR.
- wdata  input  DATA_W  write data from MDR.
- rdata  output  DATA_W  read data; held until the next completed read.
- done  output  1  one-cycle pulse when an access completes.
- busy  output  1  high from request capture until done inclusive.
- err  output  1  one-cycle pulse on an illegal request (read and write together).
- overrun  output  1  sticky flag: a new request edge was seen while busy.

Behaviour:
- Reset values: rdata=0, done=0, busy=0, err=0, overrun=0, FSM=IDLE, wait counter=0. RAM contents are NOT cleared by reset.
- Request detection: the block registers read_d and write_d and detects rising edges (read & ~read_d, write & ~write_d). A level held high does not retrigger.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE, single request edge: capture addr, wdata and the op into internal registers; busy=1. Go to WAIT if WAIT_STATES>0, otherwise ACCESS. Load the counter with WAIT_STATES-1.
  - IDLE, read edge and write edge in the same cycle: err pulses for 1 cycle, nothing is captured, stay in IDLE.
  - WAIT: decrement the counter; go to ACCESS when the counter is 0.
  - ACCESS: on a write, mem[cap_addr] <= cap_wdata. On a read, rdata <= mem[cap_addr]. Go to DONE.
  - DONE: done=1 for exactly this cycle, busy still 1. Go to IDLE; busy=0 the cycle after.
- Latency: request edge sampled at edge N -> done high during cycle N+WAIT_STATES+2; with WAIT_STATES=2, done is high at N+4. rdata is valid no later than the cycle done is high.
- Captured operands: changes on addr/wdata after capture have no effect on the access in progress.
- Requests while busy: any rising edge on read or write outside IDLE is ignored and sets overrun=1. overrun clears only on reset.
- Request edge in the DONE cycle: counts as while busy; it is ignored and sets overrun.
- Address: always in range by width; no wrap logic needed.
- Write path: rdata is unchanged by writes.
- Reset mid-access: the FSM returns to IDLE immediately and no pending write is committed. Any location already written keeps its value.
- Edge detector after reset: read_d and write_d reset to 0, so a level already high when reset deasserts is detected as an edge on the first clock.

Test Plan:
- Write then read, WAIT_STATES=2: write edge, addr=0x05C, wdata=0xDEADBEEF -> done at N+4, busy high N+1..N+4. Then a read edge at addr=0x05C -> rdata=0xDEADBEEF when done pulses.
- Operand capture: read edge at addr=0x010 holding 0x00000011; change addr to 0x011 one cycle later -> rdata=0x00000011.
- Illegal request: read and write rise in the same cycle from IDLE -> err=1 for one cycle, busy stays 0, the target location is unchanged.
- Overrun: read edge, then drop read and raise write mid-WAIT -> first read completes normally, no write occurs, overrun=1 and stays 1 until reset.
- Reset mid-write: write edge to 0x020 with 0x12345678 (location previously 0xCAFEF00D); assert reset during WAIT -> all outputs 0. A subsequent read of 0x020 returns 0xCAFEF00D.
- WAIT_STATES=0 build: a read edge at N -> done at N+2. Back-to-back reads with read toggled every 3 cycles -> each completes and overrun stays 0.
